pic_ack_sequencer: RTL and testbench
====================================

Name: pic_ack_sequencer

Overview:
- Downstream stage of the interrupt block. Consumes the "interrupt pending" flag and the resolved 3-bit level from the priority resolver.
- Raises the CPU interrupt line and runs the 8086-style two-pulse INTA handshake. It owns the 8-bit in-service register (ISR).
- Drives the interrupt vector onto the data bus and processes EOI/AEOI.
- Returns a one-hot clear strobe to the request register so that the acknowledged request is retired.

Parameters:
- VEC_W, 8, data bus / vector width.
- NUM_IRQ, 8, number of interrupt levels (fixed at 8; level id is 3 bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- int_in  in  1  request pending from the interrupt block (already masked).
- chosen_id  in  3  highest-priority pending level from the resolver; valid while int_in=1.
- inta_n  in  1  CPU acknowledge, active low. Synchronous to clk.
- vec_base  in  5  vector base T7..T3 from ICW2.
- aeoi  in  1  automatic-EOI mode enable.
- eoi_valid  in  1  one-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_level  in  3  level cleared by a specific EOI.
- int_out  out  1  interrupt line to the CPU.
- data_out  out  8  vector byte.
- data_oe  out  1  data bus drive enable.
- isr  out  8  in-service register.
- irr_clear  out  8  one-hot, one-cycle request-clear strobe to the request register.
- spurious  out  1  one-cycle pulse when an acknowledge finds no request.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - Outputs: int_out=0, data_out=0, data_oe=0, isr=0, irr_clear=0, spurious=0.
  - Internal: state=IDLE, latched id=0, inta_n_q=1.
  - Reset mid-handshake abandons the cycle. No ISR bit survives.
- INTA edge detection:
  - inta_n_q is registered inta_n.
  - fall = inta_n_q & ~inta_n; rise = ~inta_n_q & inta_n.
- Nesting gate (fully nested, level 0 highest):
  - block = OR of isr[k] for k <= chosen_id (equal or higher priority already in service).
  - int_out is registered: int_out <= int_in & ~block while state=IDLE. Latency is 1 cycle from int_in.
- FSM states: IDLE, ACK1, GAP, ACK2.
- IDLE:
  - On fall: go to ACK1 and clear int_out.
  - If int_in & ~block: latch id=chosen_id, set isr[id], pulse irr_clear[id] for 1 cycle.
  - Otherwise: latch id=7, pulse spurious, and set no ISR bit.
  - A fall with int_out=0 is handled by the same rule.
- ACK1:
  - data_oe=0 throughout.
  - On rise: go to GAP.
- GAP:
  - On fall: go to ACK2, data_out <= {vec_base, id}, data_oe <= 1.
- ACK2:
  - data_oe stays 1 while inta_n is low. data_out is held stable.
  - On rise: data_oe <= 0 and go to IDLE.
  - If aeoi=1 and not spurious: clear isr[id] on the same edge.
- EOI (accepted in any state):
  - Non-specific: clear the lowest-numbered set isr bit. No-op if isr=0.
  - Specific: clear isr[eoi_level]. No-op if already clear.
- Simultaneous events:
  - A set and a clear of the same isr bit in one cycle: set wins.
  - Different bits: both take effect.
  - Non-specific EOI selects its target from isr as registered before this cycle's set.
- int_out is never asserted outside IDLE.
- After return to IDLE, the gate is re-evaluated the next cycle, so int_out can re-assert 1 cycle after the ACK2 rise.
- irr_clear and spurious are single-cycle pulses, 0 otherwise.

Decomposition:
- Shared package pic_pkg:
  - state enum (IDLE, ACK1, GAP, ACK2);
  - SPURIOUS_ID=3'd7;
  - function lowest_set(isr) returning a 3-bit index plus a found flag.
- Sub-module pic_isr_reg: holds isr[7:0]. Applies set(id), AEOI clear, specific/non-specific EOI with the precedence rules above, and computes the block mask.
- pic_ack_sequencer instantiates pic_isr_reg and contains the FSM, edge detection and data path.

Test Plan:
- Basic ack, vec_base=5'b01000, aeoi=0: int_in=1, chosen_id=3 → int_out=1 after 1 cycle. First INTA fall → isr=8'h08, irr_clear=8'h08 pulse, int_out=0. Second INTA → data_out=8'h43, data_oe=1 only while inta_n low. Non-specific EOI → isr=0.
- Nesting: isr=8'h08 in service, chosen_id=5 → int_out stays 0. chosen_id=1 → int_out=1. After ack, isr=8'h0A. Non-specific EOI → isr=8'h08.
- AEOI=1, chosen_id=6, vec_base=5'b11111 → vector 8'hFE; isr bit 6 set during the cycle and cleared on the ACK2 rise; final isr=0.
- Spurious: int_out=1 for id 2, int_in drops before the INTA fall → spurious pulse, isr unchanged, irr_clear=0, vector = {vec_base,3'd7}.
- Collision: specific EOI for level 4 in the same cycle as the ISR set for level 4 → isr[4]=1. Specific EOI for 2 with a set for 4 → isr[2]=0, isr[4]=1.
- Reset in GAP with isr=8'h10 → next cycle state IDLE, isr=0, data_oe=0, int_out=0. A subsequent clean ack completes normally.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and helpers for the interrupt acknowledge sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    GAP  = 2'd2,
    ACK2 = 2'd3
  } state_t;

  localparam logic [2:0] SPURIOUS_ID = 3'd7;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } lowest_t;

  function automatic lowest_t lowest_set(input logic [7:0] v);
    lowest_t r;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) begin
        r.found = 1'b1;
        r.idx   = 3'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_ack_sequencer_isr_reg.sv
// In-service register: set on acknowledge, cleared by AEOI or EOI; also
// produces the fully-nested block flag for the currently chosen level.
module pic_isr_reg
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [2:0]         set_id,
  input  logic               aeoi_clr,
  input  logic [2:0]         aeoi_id,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [2:0]         eoi_level,
  input  logic [2:0]         chosen_id,
  output logic [NUM_IRQ-1:0] isr,
  output logic               block
);

  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] le_mask;
  lowest_t            low;

  assign low = lowest_set(isr);

  always_comb begin
    set_mask = '0;
    if (set_en) set_mask[set_id] = 1'b1;
  end

  // Non-specific EOI picks its target from the pre-set register value.
  always_comb begin
    clr_mask = '0;
    if (aeoi_clr) clr_mask[aeoi_id] = 1'b1;
    if (eoi_valid) begin
      if (eoi_specific)   clr_mask[eoi_level] = 1'b1;
      else if (low.found) clr_mask[low.idx]   = 1'b1;
    end
  end

  always_comb begin
    le_mask = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (3'(k) <= chosen_id) le_mask[k] = 1'b1;
    end
  end

  assign block = |(isr & le_mask);

  // Set is OR-ed in after the clear so it wins on the same bit.
  always_ff @(posedge clk) begin
    if (rst) isr <= '0;
    else     isr <= (isr & ~clr_mask) | set_mask;
  end

endmodule

// File: rtl/pic_ack_sequencer.sv
// Two-pulse INTA handshake sequencer: raises int_out, retires requests,
// drives the vector and owns the in-service register.
//   state | meaning
//   IDLE  | waiting; int_out follows the nesting gate
//   ACK1  | first INTA pulse low, level latched and ISR set
//   GAP   | between pulses, waiting for second fall
//   ACK2  | second pulse low, vector driven on the bus
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int VEC_W   = 8,
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               int_in,
  input  logic [2:0]         chosen_id,
  input  logic               inta_n,
  input  logic [VEC_W-4:0]   vec_base,
  input  logic               aeoi,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [2:0]         eoi_level,
  output logic               int_out,
  output logic [VEC_W-1:0]   data_out,
  output logic               data_oe,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic               spurious
);

  state_t             state, state_nxt;
  logic               inta_n_q;
  logic               fall, rise;
  logic [2:0]         id_q, id_nxt;
  logic               spur_q, spur_nxt;
  logic               block, grant;
  logic               set_en, aeoi_clr;
  logic               int_out_nxt, data_oe_nxt, spurious_nxt;
  logic [VEC_W-1:0]   data_out_nxt;
  logic [NUM_IRQ-1:0] irr_clear_nxt;

  assign fall  = inta_n_q & ~inta_n;
  assign rise  = ~inta_n_q & inta_n;
  assign grant = int_in & ~block;

  pic_isr_reg #(.NUM_IRQ(NUM_IRQ)) u_isr (
    .clk          (clk),
    .rst          (rst),
    .set_en       (set_en),
    .set_id       (chosen_id),
    .aeoi_clr     (aeoi_clr),
    .aeoi_id      (id_q),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .chosen_id    (chosen_id),
    .isr          (isr),
    .block        (block)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    id_nxt        = id_q;
    spur_nxt      = spur_q;
    int_out_nxt   = 1'b0;
    data_out_nxt  = data_out;
    data_oe_nxt   = data_oe;
    irr_clear_nxt = '0;
    spurious_nxt  = 1'b0;
    set_en        = 1'b0;
    aeoi_clr      = 1'b0;
    case (state)
      IDLE: begin
        int_out_nxt = grant;
        if (fall) begin
          state_nxt   = ACK1;
          int_out_nxt = 1'b0;
          if (grant) begin
            id_nxt                   = chosen_id;
            spur_nxt                 = 1'b0;
            set_en                   = 1'b1;
            irr_clear_nxt[chosen_id] = 1'b1;
          end else begin
            id_nxt       = SPURIOUS_ID;
            spur_nxt     = 1'b1;
            spurious_nxt = 1'b1;
          end
        end
      end
      ACK1: begin
        data_oe_nxt = 1'b0;
        if (rise) state_nxt = GAP;
      end
      GAP: begin
        if (fall) begin
          state_nxt    = ACK2;
          data_out_nxt = {vec_base, id_q};
          data_oe_nxt  = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          state_nxt   = IDLE;
          data_oe_nxt = 1'b0;
          aeoi_clr    = aeoi & ~spur_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inta_n_q  <= 1'b1;
      id_q      <= '0;
      spur_q    <= 1'b0;
      int_out   <= 1'b0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      irr_clear <= '0;
      spurious  <= 1'b0;
    end else begin
      inta_n_q  <= inta_n;
      id_q      <= id_nxt;
      spur_q    <= spur_nxt;
      int_out   <= int_out_nxt;
      data_out  <= data_out_nxt;
      data_oe   <= data_oe_nxt;
      irr_clear <= irr_clear_nxt;
      spurious  <= spurious_nxt;
    end
  end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Scoreboard bench for pic_ack_sequencer: stimulus queues expected strobes
// and vectors, a negedge monitor retires them; state checks are inline.
module tb_pic_ack_sequencer;

  localparam int K_CLR  = 0;
  localparam int K_SPUR = 1;
  localparam int K_VEC  = 2;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_in;
  logic [2:0] chosen_id;
  logic       inta_n;
  logic [4:0] vec_base;
  logic       aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] isr;
  logic [7:0] irr_clear;
  logic       spurious;

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  logic oe_prev = 1'b0;

  always #5 clk = ~clk;

  pic_ack_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .int_in       (int_in),
    .chosen_id    (chosen_id),
    .inta_n       (inta_n),
    .vec_base     (vec_base),
    .aeoi         (aeoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .int_out      (int_out),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .isr          (isr),
    .irr_clear    (irr_clear),
    .spurious     (spurious)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Full two-pulse handshake; optional EOI strobe coincides with the first fall.
  task automatic inta_cycle(input logic e, input logic s, input logic [2:0] l);
    inta_n = 1'b0; eoi_valid = e; eoi_specific = s; eoi_level = l;
    step(1);
    eoi_valid = 1'b0; int_in = 1'b0; inta_n = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(2);
    inta_n = 1'b1;
    step(1);
  endtask

  task automatic eoi(input logic s, input logic [2:0] l);
    eoi_valid = 1'b1; eoi_specific = s; eoi_level = l;
    step(1);
    eoi_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (irr_clear != 8'h00 || spurious || (data_oe && !oe_prev)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event irr_clear=%h spurious=%b data_oe=%b", irr_clear, spurious, data_oe);
        end else begin
          e = sb.pop_front();
          if (irr_clear != 8'h00) begin
            if (e.kind != K_CLR || irr_clear !== e.val) begin
              errors++;
              $display("FAIL irr_clear actual=%h required kind=%0d val=%h", irr_clear, e.kind, e.val);
            end
          end else if (spurious) begin
            if (e.kind != K_SPUR || irr_clear !== 8'h00) begin
              errors++;
              $display("FAIL spurious actual irr_clear=%h required kind=%0d", irr_clear, e.kind);
            end
          end else begin
            if (e.kind != K_VEC || data_out !== e.val) begin
              errors++;
              $display("FAIL vector actual=%h required kind=%0d val=%h", data_out, e.kind, e.val);
            end
          end
        end
      end
    end
    oe_prev = data_oe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; int_in = 1'b0; chosen_id = 3'd0; inta_n = 1'b1;
    vec_base = 5'b01000; aeoi = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    step(2);
    chk("rst_int_out", {7'd0, int_out}, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_data_oe", {7'd0, data_oe}, 8'h00);
    chk("rst_data_out", data_out, 8'h00);
    rst = 1'b0;
    step(1);

    // Basic acknowledge of level 3
    int_in = 1'b1; chosen_id = 3'd3;
    step(1);
    chk("basic_int_out", {7'd0, int_out}, 8'h01);
    expect_ev(K_CLR, 8'h08);
    expect_ev(K_VEC, 8'h43);
    inta_n = 1'b0;
    step(1);
    chk("basic_isr_set", isr, 8'h08);
    chk("basic_int_out_drop", {7'd0, int_out}, 8'h00);
    int_in = 1'b0; inta_n = 1'b1;
    step(2);
    chk("basic_oe_gap", {7'd0, data_oe}, 8'h00);
    inta_n = 1'b0;
    step(1);
    chk("basic_oe_on", {7'd0, data_oe}, 8'h01);
    step(1);
    chk("basic_oe_held", {7'd0, data_oe}, 8'h01);
    chk("basic_data_held", data_out, 8'h43);
    inta_n = 1'b1;
    step(1);
    chk("basic_oe_off", {7'd0, data_oe}, 8'h00);
    chk("basic_isr_kept", isr, 8'h08);
    eoi(1'b0, 3'd0);
    chk("basic_eoi", isr, 8'h00);

    // Nesting against level 3 in service
    int_in = 1'b1; chosen_id = 3'd3;
    step(1);
    expect_ev(K_CLR, 8'h08);
    expect_ev(K_VEC, 8'h43);
    inta_cycle(1'b0, 1'b0, 3'd0);
    chk("nest_isr3", isr, 8'h08);
    int_in = 1'b1; chosen_id = 3'd5;
    step(2);
    chk("nest_blocked", {7'd0, int_out}, 8'h00);
    chosen_id = 3'd1;
    step(1);
    chk("nest_allowed", {7'd0, int_out}, 8'h01);
    expect_ev(K_CLR, 8'h02);
    expect_ev(K_VEC, 8'h41);
    inta_cycle(1'b0, 1'b0, 3'd0);
    chk("nest_isr_0a", isr, 8'h0A);
    eoi(1'b0, 3'd0);
    chk("nest_eoi_ns", isr, 8'h08);
    eoi(1'b1, 3'd3);
    chk("nest_eoi_sp", isr, 8'h00);

    // Automatic EOI
    aeoi = 1'b1; vec_base = 5'b11111; int_in = 1'b1; chosen_id = 3'd6;
    step(1);
    chk("aeoi_int_out", {7'd0, int_out}, 8'h01);
    expect_ev(K_CLR, 8'h40);
    expect_ev(K_VEC, 8'hFE);
    inta_n = 1'b0;
    step(1);
    chk("aeoi_isr_set", isr, 8'h40);
    int_in = 1'b0; inta_n = 1'b1;
    step(2);
    inta_n = 1'b0;
    step(2);
    chk("aeoi_isr_ack2", isr, 8'h40);
    inta_n = 1'b1;
    step(1);
    chk("aeoi_isr_clr", isr, 8'h00);
    aeoi = 1'b0; vec_base = 5'b01000;

    // Spurious: request withdrawn before the first fall
    int_in = 1'b1; chosen_id = 3'd2;
    step(1);
    chk("spur_int_out", {7'd0, int_out}, 8'h01);
    int_in = 1'b0;
    expect_ev(K_SPUR, 8'h00);
    expect_ev(K_VEC, 8'h47);
    inta_cycle(1'b0, 1'b0, 3'd0);
    chk("spur_isr", isr, 8'h00);

    // Collisions between ISR set and EOI
    int_in = 1'b1; chosen_id = 3'd4;
    step(1);
    expect_ev(K_CLR, 8'h10);
    expect_ev(K_VEC, 8'h44);
    inta_cycle(1'b1, 1'b1, 3'd4);
    chk("coll_same_bit", isr, 8'h10);
    eoi(1'b1, 3'd4);
    int_in = 1'b1; chosen_id = 3'd6;
    step(1);
    expect_ev(K_CLR, 8'h40);
    expect_ev(K_VEC, 8'h46);
    inta_cycle(1'b0, 1'b0, 3'd0);
    int_in = 1'b1; chosen_id = 3'd4;
    step(1);
    expect_ev(K_CLR, 8'h10);
    expect_ev(K_VEC, 8'h44);
    inta_cycle(1'b1, 1'b1, 3'd6);
    chk("coll_diff_bits", isr, 8'h10);
    int_in = 1'b1; chosen_id = 3'd1;
    step(1);
    expect_ev(K_CLR, 8'h02);
    expect_ev(K_VEC, 8'h41);
    inta_cycle(1'b1, 1'b0, 3'd0);
    chk("coll_ns_preset", isr, 8'h02);
    eoi(1'b0, 3'd0);
    chk("coll_ns_final", isr, 8'h00);

    // Reset while between pulses
    int_in = 1'b1; chosen_id = 3'd4;
    step(1);
    expect_ev(K_CLR, 8'h10);
    inta_n = 1'b0;
    step(1);
    int_in = 1'b0; inta_n = 1'b1;
    step(1);
    chk("gap_isr", isr, 8'h10);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("gap_rst_isr", isr, 8'h00);
    chk("gap_rst_oe", {7'd0, data_oe}, 8'h00);
    chk("gap_rst_int", {7'd0, int_out}, 8'h00);
    step(1);
    int_in = 1'b1; chosen_id = 3'd3;
    step(1);
    chk("post_rst_int", {7'd0, int_out}, 8'h01);
    expect_ev(K_CLR, 8'h08);
    expect_ev(K_VEC, 8'h43);
    inta_cycle(1'b0, 1'b0, 3'd0);
    chk("post_rst_isr", isr, 8'h08);
    eoi(1'b0, 3'd0);
    step(3);
    chk("sb_drained", 8'(sb.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
